// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared constants, state encoding and priority encoder for the ball pool
package ball_pkg;

  localparam int NUM_BALLS = 8;
  localparam int SIZE_W    = 2;
  localparam int IDX_W     = 3;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {IDLE, RUN, SPLIT, CLEAR} pool_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Lowest set bit wins; scanning downward lets the last hit overwrite.
  function automatic prio_t prio_enc(input logic [NUM_BALLS-1:0] vec);
    prio_t r;
    r = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_draw_mux.sv
// rtl/ball_draw_mux.sv - fixed-priority merge of per-object draw requests into one layer
module ball_draw_mux #(
  parameter int         N      = 8,
  parameter int         W      = 8,
  parameter logic [7:0] TRANSP = 8'hFF
) (
  input  logic [N-1:0]   reqVec,
  input  logic [N*W-1:0] dataVec,
  output logic           req,
  output logic [W-1:0]   data
);

  // Combinational so the merged layer stays aligned with the registered bitmap outputs.
  always_comb begin
    req  = 1'b0;
    data = W'(TRANSP);
    for (int i = N - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        req  = 1'b1;
        data = dataVec[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/ball_pool_ctrl.sv
// rtl/ball_pool_ctrl.sv - ball slot allocation, split/retire sequencing and level-clear detection
module ball_pool_ctrl
  import ball_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    levelStart,
  input  logic [SIZE_W-1:0]       initSize,
  input  logic [NUM_BALLS-1:0]    hitVec,
  input  logic [NUM_BALLS-1:0]    drawReqVec,
  input  logic [NUM_BALLS*8-1:0]  rgbVec,
  output logic [NUM_BALLS-1:0]    visibleVec,
  output logic [NUM_BALLS*SIZE_W-1:0] sizeVec,
  output logic                    spawnValid,
  output logic [IDX_W-1:0]        spawnParent,
  output logic [IDX_W-1:0]        spawnChild,
  output logic                    spawnChildValid,
  output logic [SIZE_W-1:0]       spawnSize,
  output logic                    ballDrawingRequest,
  output logic [7:0]              ballRGB,
  output logic                    levelClear,
  output logic [IDX_W:0]          activeCount
);

  pool_state_t          state_q, state_n;
  logic [NUM_BALLS-1:0] pending_q, pending_n;
  logic [NUM_BALLS-1:0] mask_q, mask_n;
  logic [NUM_BALLS-1:0] visible_n, capture;
  logic [SIZE_W-1:0]    size_q [NUM_BALLS];
  logic [SIZE_W-1:0]    size_n [NUM_BALLS];
  logic [SIZE_W-1:0]    new_size;
  logic [IDX_W-1:0]     p_idx, c_idx;
  logic                 sv_n, scv_n, lc_n;
  logic [IDX_W-1:0]     sp_n, sc_n;
  logic [SIZE_W-1:0]    ss_n;
  logic [IDX_W:0]       cnt_n;
  prio_t                pend_sel, free_sel;

  assign capture  = hitVec & visibleVec & ~mask_q;
  assign pend_sel = prio_enc(pending_q);
  assign free_sel = prio_enc(~visibleVec & ~mask_q);
  assign p_idx    = pend_sel.idx;
  assign c_idx    = free_sel.idx;
  assign new_size = size_q[p_idx] - 1'b1;

  always_comb begin
    state_n   = state_q;
    pending_n = pending_q;
    mask_n    = mask_q;
    visible_n = visibleVec;
    size_n    = size_q;
    sv_n      = 1'b0;
    sp_n      = '0;
    sc_n      = '0;
    scv_n     = 1'b0;
    ss_n      = '0;
    lc_n      = 1'b0;

    if (startOfFrame) mask_n = '0;

    if (levelStart) begin
      state_n   = RUN;
      pending_n = '0;
      mask_n    = '0;
      visible_n = NUM_BALLS'(1);
      for (int i = 0; i < NUM_BALLS; i++) size_n[i] = '0;
      size_n[0] = initSize;
    end else begin
      case (state_q)
        RUN: begin
          pending_n = pending_q | capture;
          if (pending_q != '0) begin
            state_n = SPLIT;
          end else if (visibleVec == '0) begin
            state_n = CLEAR;
            lc_n    = 1'b1;
          end
        end
        SPLIT: begin
          pending_n = pending_q | capture;
          if (pend_sel.found) begin
            // Clearing after the OR drops a same-cycle hit on p instead of re-queuing it.
            pending_n[p_idx] = 1'b0;
            mask_n[p_idx]    = 1'b1;
            sv_n             = 1'b1;
            sp_n             = p_idx;
            if (size_q[p_idx] != '0) begin
              size_n[p_idx] = new_size;
              ss_n          = new_size;
              if (free_sel.found) begin
                visible_n[c_idx] = 1'b1;
                size_n[c_idx]    = new_size;
                mask_n[c_idx]    = 1'b1;
                scv_n            = 1'b1;
                sc_n             = c_idx;
              end
            end else begin
              visible_n[p_idx] = 1'b0;
            end
          end
          state_n = (pending_n != '0) ? SPLIT : RUN;
        end
        CLEAR:   state_n = IDLE;
        default: state_n = state_q;
      endcase
    end

    cnt_n = '0;
    for (int i = 0; i < NUM_BALLS; i++) cnt_n = cnt_n + (IDX_W+1)'(visible_n[i]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      mask_q          <= '0;
      visibleVec      <= '0;
      size_q          <= '{default: '0};
      spawnValid      <= 1'b0;
      spawnParent     <= '0;
      spawnChild      <= '0;
      spawnChildValid <= 1'b0;
      spawnSize       <= '0;
      levelClear      <= 1'b0;
      activeCount     <= '0;
    end else begin
      state_q         <= state_n;
      pending_q       <= pending_n;
      mask_q          <= mask_n;
      visibleVec      <= visible_n;
      size_q          <= size_n;
      spawnValid      <= sv_n;
      spawnParent     <= sp_n;
      spawnChild      <= sc_n;
      spawnChildValid <= scv_n;
      spawnSize       <= ss_n;
      levelClear      <= lc_n;
      activeCount     <= cnt_n;
    end
  end

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_size
    assign sizeVec[g*SIZE_W +: SIZE_W] = size_q[g];
  end

  ball_draw_mux #(
    .N      (NUM_BALLS),
    .W      (8),
    .TRANSP (TRANSPARENT_ENCODING)
  ) u_draw_mux (
    .reqVec  (drawReqVec),
    .dataVec (rgbVec),
    .req     (ballDrawingRequest),
    .data    (ballRGB)
  );

endmodule

// File: doc/ball_pool_ctrl.md
Name: ball_pool_ctrl

Overview:
- Manages a fixed pool of ball slots for the game: spawns the level's first ball, splits a ball into two smaller ones when it is hit, retires the smallest balls, and detects when the level is cleared.
- Drives the per-slot visible and size inputs of the ball bitmap/movement instances.
- Merges their drawing requests into one ball layer for the video mux, using a fixed priority.

Parameters:
- NUM_BALLS, 8, number of ball slots (bitmap instances).
- SIZE_W, 2, width of the size level; 0 = smallest.
- IDX_W, 3, slot index width; must equal clog2(NUM_BALLS).

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- levelStart  in  1  one-cycle pulse: restart the pool
- initSize  in  SIZE_W  size of the level's first ball, sampled on levelStart
- hitVec  in  NUM_BALLS  per-slot rope/shot collision; may stay high for many pixels
- drawReqVec  in  NUM_BALLS  per-slot drawingRequest from the bitmaps
- rgbVec  in  NUM_BALLS*8  per-slot RGBout; slot i occupies bits [8i+7:8i]
- visibleVec  out  NUM_BALLS  per-slot visible control
- sizeVec  out  NUM_BALLS*SIZE_W  per-slot size level
- spawnValid  out  1  one-cycle pulse: a split was processed
- spawnParent  out  IDX_W  index of the slot that was hit
- spawnChild  out  IDX_W  index of the newly allocated slot
- spawnChildValid  out  1  a child slot was allocated (qualified by spawnValid)
- spawnSize  out  SIZE_W  new size of the parent and the child
- ballDrawingRequest  out  1  merged draw request
- ballRGB  out  8  merged colour
- levelClear  out  1  one-cycle pulse: all balls are gone
- activeCount  out  IDX_W+1  number of visible slots

Behaviour:
- Reset: all outputs 0, state IDLE, pending and mask registers cleared.
- States: IDLE, RUN, SPLIT, CLEAR.
- levelStart in any state has priority over everything else. Next cycle:
  - visibleVec = 1 (slot 0 only), size[0] = initSize, all other sizes 0;
  - pending and mask cleared, state RUN.
- Hit capture, every cycle in RUN or SPLIT: pending |= hitVec & visibleVec & ~mask.
  - mask is cleared on startOfFrame.
  - A slot is masked when its hit is processed, so one collision splits a slot at most once per frame.
  - A hit on an invisible slot is ignored.
- RUN:
  - If pending != 0, go to SPLIT.
  - Else if visibleVec == 0, go to CLEAR.
  - Else stay in RUN.
- SPLIT: process exactly one pending slot p per cycle, lowest index first. Clear pending[p], set mask[p].
  - size[p] > 0:
    - size[p] -= 1;
    - allocate the lowest-index slot c with visible = 0 and mask = 0, set visible[c] = 1 and size[c] = size[p] - 1, set mask[c];
    - if no free slot exists, the parent shrinks anyway and spawnChildValid = 0.
  - size[p] == 0: visible[p] = 0 and no child is created. spawnChildValid = 0, spawnSize = 0.
  - In every SPLIT cycle, spawnValid pulses the cycle after processing (registered) with spawnParent = p, spawnChild = c, and spawnSize = the parent's new size.
  - Movement blocks copy the parent's position into c and give c the opposite x direction.
  - After processing: if pending is still nonzero, stay in SPLIT; otherwise return to RUN.
  - A hit arriving in the same cycle as its slot is processed is masked, not re-queued.
  - startOfFrame coinciding with a SPLIT cycle: clear mask first, then apply the new mask bit.
- CLEAR: pulse levelClear for one cycle, then go to IDLE. visibleVec stays 0.
- IDLE: ignore hitVec. Leave only on levelStart.
- activeCount: registered popcount of the next visibleVec, so it updates in the same cycle as visibleVec.
- Draw merge (combinational, zero latency, so it stays aligned with the registered bitmap outputs):
  - the lowest index i with drawReqVec[i] = 1 wins: ballRGB = rgbVec[i], ballDrawingRequest = 1;
  - if no slot requests, ballDrawingRequest = 0 and ballRGB = 8'hFF (transparent).
- Width rules:
  - Size arithmetic is unsigned; decrement happens only when size > 0, so it never wraps.
  - Index search is lowest-index-first over exactly NUM_BALLS bits.

Decomposition:
- Package ball_pkg holds:
  - NUM_BALLS, SIZE_W, IDX_W;
  - TRANSPARENT_ENCODING = 8'hFF;
  - state enum pool_state_t {IDLE, RUN, SPLIT, CLEAR};
  - a priority-encoder function (lowest set bit -> index, plus a found flag), shared by pending selection and free-slot search.
- Sub-module ball_draw_mux: the parameterised combinational priority merge of drawReqVec/rgbVec. It is reused later for the player/shot layers.

Test Plan:
- Reset then levelStart with initSize = 2 -> visibleVec = 8'h01, size[0] = 2, activeCount = 1, state RUN.
- hitVec[0] held for 40 cycles within one frame -> exactly one spawnValid with parent = 0, child = 1, spawnSize = 1, spawnChildValid = 1; visibleVec = 8'h03. Same hit in the next frame -> slot 0 splits again with child = 2 and size 0.
- Simultaneous hits on slots 3 and 1, both size 1 -> slot 1 processed first, then slot 3 on the following cycle, children take the two lowest free slots, two spawnValid pulses in consecutive cycles.
- All 8 slots visible, hit slot 5 with size 2 -> size[5] = 1, spawnChildValid = 0, activeCount stays 8.
- Hit the last visible ball, size 0 -> visibleVec = 0, levelClear pulses exactly once, state IDLE; further hitVec has no effect.
- drawReqVec = 8'b0010_0100 with rgb[2] = 8'h1C, rgb[5] = 8'hE0 -> ballRGB = 8'h1C, request = 1. drawReqVec = 0 -> ballRGB = 8'hFF, request = 0.
- levelStart asserted mid-SPLIT with pending hits -> pending discarded, visibleVec = 8'h01 on the next cycle, no further spawnValid.
